control_ajuste: RTL and testbench
=================================

CONTROL_AJUSTE -- requirements
Module: control_ajuste

Interface
REQ-001 The block SHALL have the parameter REPEAT_DELAY, default 50000000: the number of clk cycles a single step button is held before auto-repeat starts.
REQ-002 The block SHALL have the parameter REPEAT_RATE, default 10000000: the number of clk cycles between auto-repeat steps.
REQ-003 The block SHALL have the port clk, input, 1 bit: the single clock; all logic is sensitive to its rising edge.
REQ-004 The block SHALL have the port rst_n, input, 1 bit: reset, asynchronous and active-low.
REQ-005 The block SHALL have the port au, input, 1 bit: debounced "increase" level.
REQ-006 The block SHALL have the port dis, input, 1 bit: debounced "decrease" level.
REQ-007 The block SHALL have the port sel, input, 1 bit: debounced "select field" level.
REQ-008 The block SHALL have the port horas, output, 5 bits: hours value, binary, 0-23.
REQ-009 The block SHALL have the port minutos, output, 6 bits: minutes value, binary, 0-59.
REQ-010 The block SHALL have the port segundos, output, 6 bits: seconds value, binary, 0-59.
REQ-011 The block SHALL have the port campo, output, 2 bits: field selected for editing (00 = horas, 01 = minutos, 10 = segundos).
REQ-012 The block SHALL have the port cambio, output, 1 bit: a one-cycle pulse when any value register changes.

Function
REQ-013 Inputs are already synchronous and debounced. The block SHALL register each input once to get a previous value, and SHALL treat a rising edge as: current = 1 and previous = 0.
REQ-014 Field FSM, advancing on a sel rising edge: HORAS -> MINUTOS -> SEGUNDOS -> HORAS. The unreachable code 11 SHALL go to HORAS on the next clk edge.
REQ-015 A step is applied in the same cycle as it is detected. Value outputs SHALL update on the clk edge after the input edge is sampled, i.e. 1 cycle latency from the registered edge.
REQ-016 An au rising edge with dis low SHALL increment the selected field by 1.
REQ-017 A dis rising edge with au low SHALL decrement the selected field by 1.
REQ-018 Wrap-around: horas 23 + 1 -> 0 and 0 - 1 -> 23. Minutos and segundos 59 + 1 -> 0 and 0 - 1 -> 59. No value SHALL ever leave its range.
REQ-019 When au and dis are both high, no step SHALL occur and the repeat counter SHALL be held at 0.
REQ-020 When a sel rising edge occurs in the same cycle as an au or dis edge, the field SHALL advance and no step SHALL be applied in that cycle.
REQ-021 Auto-repeat setup: a 27-bit repeat counter SHALL clear on each au or dis rising edge and count while exactly one of au or dis stays high.
REQ-022 Auto-repeat timing: when the counter reaches REPEAT_DELAY, the block SHALL apply one step in the held direction. After that, it SHALL apply one step every REPEAT_RATE cycles until release.
REQ-023 Releasing the held button, or pressing the other one, SHALL stop the repeat and clear the counter.
REQ-024 A change of field during a hold SHALL clear the counter. Any later repeat steps SHALL apply to the new field.
REQ-025 cambio SHALL be 1 for exactly the cycle after each applied step. It SHALL NOT pulse on a field change.

Reset
REQ-026 While rst_n = 0, the block SHALL asynchronously force: horas = 0, minutos = 0, segundos = 0, campo = 00, cambio = 0, repeat counter = 0, previous-value registers = 0.
REQ-027 An arm flag, cleared by reset, SHALL block edge detection in the first cycle after rst_n goes high. A button already held at reset release SHALL NOT produce a step or a field change.
REQ-028 Reset asserted during a hold or a repeat SHALL abort it at once. After release, the held button SHALL need a new rising edge before it acts.

Verification (REPEAT_DELAY = 8, REPEAT_RATE = 4)
REQ-029 Scenario 1: reset, then 24 separate au pulses with campo = 00 -> horas counts 1..23 and then 0, with 24 cambio pulses.
REQ-030 Scenario 2: one sel pulse, then one dis pulse -> campo = 01 and minutos = 59. A second sel pulse then gives campo = 10.
REQ-031 Scenario 3: hold au for 20 cycles with campo = 10 -> segundos = 4 (edge step, then repeats at cycles 8, 12 and 16), then no further change after release.
REQ-032 Scenario 4: au and dis rise in the same cycle, and sel and au rise in the same cycle -> no value change and no cambio; campo advances once.
REQ-033 Scenario 5: au held high through a reset release -> all values stay 0 and no cambio; the next new au edge gives horas = 1.
REQ-034 Scenario 6: rst_n pulsed low mid-repeat, between clk edges -> outputs go to 0 without waiting for a clk edge; no repeat step follows.

Source files
------------

// File: rtl/control_ajuste.sv
// Time-setting controller: au/dis step the selected field (h/m/s) with wrap and auto-repeat, sel rotates the field.
// Steps land one clk after the registered input edge; there is no backpressure and every step is taken.
module control_ajuste #(
  parameter int REPEAT_DELAY = 50000000,
  parameter int REPEAT_RATE  = 10000000
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       au,
  input  logic       dis,
  input  logic       sel,
  output logic [4:0] horas,
  output logic [5:0] minutos,
  output logic [5:0] segundos,
  output logic [1:0] campo,
  output logic       cambio
);

  typedef enum logic [1:0] {
    HORAS    = 2'b00,
    MINUTOS  = 2'b01,
    SEGUNDOS = 2'b10,
    INVALIDO = 2'b11
  } campo_t;

  localparam logic [26:0] DELAY_C   = 27'(REPEAT_DELAY);
  localparam logic [26:0] RPT_END_C = 27'(REPEAT_DELAY + REPEAT_RATE);

  campo_t      state, state_n;
  logic        au_q, dis_q, sel_q;
  logic        arm;
  logic        act, act_n;
  logic        dir_up, dir_up_n;
  logic [26:0] cnt, cnt_n;
  logic        step_up, step_dn;
  logic [4:0]  horas_n;
  logic [5:0]  minutos_n, segundos_n;
  logic        cambio_n;
  logic        au_r, dis_r, sel_r;
  logic        up_only, dn_only;
  logic [5:0]  h_wide;

  function automatic logic [5:0] wrap_step(input logic [5:0] v, input logic [5:0] maxv,
                                           input logic up);
    if (up) return (v == maxv) ? 6'd0 : v + 6'd1;
    else    return (v == 6'd0) ? maxv : v - 6'd1;
  endfunction

  // arm masks the first cycle after reset so a level held through reset is not seen as an edge
  assign au_r    = arm & au  & ~au_q;
  assign dis_r   = arm & dis & ~dis_q;
  assign sel_r   = arm & sel & ~sel_q;
  assign up_only = au & ~dis;
  assign dn_only = dis & ~au;
  assign campo   = state;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      au_q  <= 1'b0;
      dis_q <= 1'b0;
      sel_q <= 1'b0;
      arm   <= 1'b0;
    end else begin
      au_q  <= au;
      dis_q <= dis;
      sel_q <= sel;
      arm   <= 1'b1;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= HORAS;
    else        state <= state_n;
  end

  always_comb begin
    state_n = state;
    unique case (state)
      HORAS:    if (sel_r) state_n = MINUTOS;
      MINUTOS:  if (sel_r) state_n = SEGUNDOS;
      SEGUNDOS: if (sel_r) state_n = HORAS;
      default:  state_n = HORAS;
    endcase
  end

  // A hold only becomes active from a real edge, so repeats never start from a level alone.
  always_comb begin
    step_up  = 1'b0;
    step_dn  = 1'b0;
    act_n    = act;
    dir_up_n = dir_up;
    cnt_n    = cnt;
    if (au_r || dis_r) begin
      cnt_n = 27'd0;
      if (au_r && !dis) begin
        act_n    = 1'b1;
        dir_up_n = 1'b1;
        step_up  = ~sel_r;
      end else if (dis_r && !au) begin
        act_n    = 1'b1;
        dir_up_n = 1'b0;
        step_dn  = ~sel_r;
      end else begin
        act_n = 1'b0;
      end
    end else if (act) begin
      if ((dir_up && up_only) || (!dir_up && dn_only)) begin
        if (sel_r) begin
          cnt_n = 27'd0;
        end else begin
          cnt_n = cnt + 27'd1;
          if (cnt_n == DELAY_C || cnt_n == RPT_END_C) begin
            step_up = dir_up;
            step_dn = ~dir_up;
            // fold back so each further repeat is REPEAT_RATE after the previous one
            if (cnt_n == RPT_END_C) cnt_n = DELAY_C;
          end
        end
      end else begin
        act_n = 1'b0;
        cnt_n = 27'd0;
      end
    end
  end

  always_comb begin
    horas_n    = horas;
    minutos_n  = minutos;
    segundos_n = segundos;
    cambio_n   = 1'b0;
    h_wide     = wrap_step({1'b0, horas}, 6'd23, step_up);
    if (step_up || step_dn) begin
      case (state)
        HORAS: begin
          horas_n  = h_wide[4:0];
          cambio_n = 1'b1;
        end
        MINUTOS: begin
          minutos_n = wrap_step(minutos, 6'd59, step_up);
          cambio_n  = 1'b1;
        end
        SEGUNDOS: begin
          segundos_n = wrap_step(segundos, 6'd59, step_up);
          cambio_n   = 1'b1;
        end
        default: ;
      endcase
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      act      <= 1'b0;
      dir_up   <= 1'b0;
      cnt      <= 27'd0;
      horas    <= 5'd0;
      minutos  <= 6'd0;
      segundos <= 6'd0;
      cambio   <= 1'b0;
    end else begin
      act      <= act_n;
      dir_up   <= dir_up_n;
      cnt      <= cnt_n;
      horas    <= horas_n;
      minutos  <= minutos_n;
      segundos <= segundos_n;
      cambio   <= cambio_n;
    end
  end

endmodule

// File: tb/tb_control_ajuste.sv
// Directed scenarios plus random button traffic, checked every cycle against a behavioural model.
module tb_control_ajuste;

  localparam int D = 8;
  localparam int R = 4;

  logic       clk = 1'b0;
  logic       rst_n;
  logic       au, dis, sel;
  logic [4:0] horas;
  logic [5:0] minutos, segundos;
  logic [1:0] campo;
  logic       cambio;

  int passes = 0;
  int total  = 0;
  int n_camb = 0;
  int camb_mark;

  control_ajuste #(.REPEAT_DELAY(D), .REPEAT_RATE(R)) dut (
    .clk(clk), .rst_n(rst_n), .au(au), .dis(dis), .sel(sel),
    .horas(horas), .minutos(minutos), .segundos(segundos),
    .campo(campo), .cambio(cambio)
  );

  always #5 clk = ~clk;

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1);
  end

  // behavioural model: values as an array indexed by field, hold age in cycles since last clear
  int m_val[3];
  int m_mod[3] = '{24, 60, 60};
  int m_field;
  bit m_pau, m_pdis, m_psel, m_arm;
  bit m_hold, m_up;
  int m_age;
  bit m_cambio;

  task automatic model_reset();
    for (int i = 0; i < 3; i++) m_val[i] = 0;
    m_field = 0; m_pau = 0; m_pdis = 0; m_psel = 0; m_arm = 0;
    m_hold = 0; m_up = 0; m_age = 0; m_cambio = 0;
  endtask

  task automatic model_eval();
    bit ea, ed, es, step, up;
    if (!rst_n) begin
      model_reset();
      return;
    end
    ea = m_arm && au && !m_pau;
    ed = m_arm && dis && !m_pdis;
    es = m_arm && sel && !m_psel;
    step = 0; up = 0;
    if (ea || ed) begin
      m_age = 0;
      if (ea && !dis)      begin m_hold = 1; m_up = 1; step = !es; up = 1; end
      else if (ed && !au)  begin m_hold = 1; m_up = 0; step = !es; up = 0; end
      else m_hold = 0;
    end else if (m_hold) begin
      if (au != dis && au == m_up) begin
        if (es) m_age = 0;
        else begin
          m_age++;
          if (m_age == D || (m_age > D && (m_age - D) % R == 0)) begin step = 1; up = m_up; end
        end
      end else begin
        m_hold = 0; m_age = 0;
      end
    end
    if (step) m_val[m_field] = (m_val[m_field] + (up ? 1 : m_mod[m_field] - 1)) % m_mod[m_field];
    m_cambio = step;
    if (es) m_field = (m_field + 1) % 3;
    m_pau = au; m_pdis = dis; m_psel = sel; m_arm = 1;
  endtask

  task automatic check(input string tag, input int obs, input int exp);
    total++;
    assert (obs === exp) passes++;
    else $error("FAIL %s: got %0d expected %0d", tag, obs, exp);
  endtask

  task automatic check_all();
    check("horas",    int'(horas),    m_val[0]);
    check("minutos",  int'(minutos),  m_val[1]);
    check("segundos", int'(segundos), m_val[2]);
    check("campo",    int'(campo),    m_field);
    check("cambio",   int'(cambio),   int'(m_cambio));
  endtask

  task automatic cycle();
    model_eval();
    @(posedge clk);
    #1;
    check_all();
    if (cambio) n_camb++;
  endtask

  initial begin
    rst_n = 1'b0; au = 1'b0; dis = 1'b0; sel = 1'b0;
    model_reset();
    #1;
    check_all();
    cycle(); cycle();
    rst_n = 1'b1;
    cycle();

    // scenario 1: 24 au pulses on horas
    camb_mark = n_camb;
    for (int i = 0; i < 24; i++) begin
      au = 1'b1; cycle();
      check("s1_horas_step", int'(horas), (i + 1) % 24);
      au = 1'b0; cycle();
    end
    check("s1_cambio_count", n_camb - camb_mark, 24);

    // scenario 2: field to minutos, decrement wraps to 59, then segundos
    sel = 1'b1; cycle(); sel = 1'b0; cycle();
    dis = 1'b1; cycle(); dis = 1'b0; cycle();
    check("s2_campo", int'(campo), 1);
    check("s2_minutos", int'(minutos), 59);
    sel = 1'b1; cycle(); sel = 1'b0; cycle();
    check("s2_campo2", int'(campo), 2);

    // scenario 3: 20-cycle hold on segundos
    au = 1'b1;
    repeat (20) cycle();
    au = 1'b0;
    repeat (10) cycle();
    check("s3_segundos", int'(segundos), 4);

    // scenario 4: simultaneous edges
    camb_mark = n_camb;
    au = 1'b1; dis = 1'b1; cycle(); cycle();
    au = 1'b0; dis = 1'b0; cycle();
    sel = 1'b1; au = 1'b1; cycle();
    sel = 1'b0; au = 1'b0; repeat (3) cycle();
    check("s4_campo", int'(campo), 0);
    check("s4_segundos", int'(segundos), 4);
    check("s4_no_cambio", n_camb - camb_mark, 0);

    // scenario 5: au held through reset release
    au = 1'b1; cycle();
    rst_n = 1'b0; model_reset();
    #1;
    check("s5_async_horas", int'(horas), 0);
    check("s5_async_segundos", int'(segundos), 0);
    cycle(); cycle();
    rst_n = 1'b1;
    camb_mark = n_camb;
    repeat (20) cycle();
    check("s5_horas_held", int'(horas), 0);
    check("s5_no_cambio", n_camb - camb_mark, 0);
    au = 1'b0; cycle();
    au = 1'b1; cycle();
    au = 1'b0; cycle();
    check("s5_horas_new_edge", int'(horas), 1);

    // scenario 6: reset between clock edges mid-repeat
    au = 1'b1;
    repeat (12) cycle();
    check("s6_horas_before", int'(horas), 3);
    #2;
    rst_n = 1'b0; model_reset();
    #1;
    check("s6_async_horas", int'(horas), 0);
    check("s6_async_cambio", int'(cambio), 0);
    check("s6_async_campo", int'(campo), 0);
    cycle(); cycle();
    rst_n = 1'b1;
    camb_mark = n_camb;
    repeat (20) cycle();
    check("s6_no_repeat", int'(horas), 0);
    check("s6_no_cambio", n_camb - camb_mark, 0);
    au = 1'b0; cycle();

    // random button traffic with long holds so repeats and wraps occur
    for (int i = 0; i < 1500; i++) begin
      if ($urandom_range(0, 9) == 0)  au  = ~au;
      if ($urandom_range(0, 11) == 0) dis = ~dis;
      if ($urandom_range(0, 19) == 0) sel = ~sel;
      cycle();
    end

    $display("%0d/%0d checks passed", passes, total);
    $finish;
  end

endmodule
